f3_predecoder_pipe: RTL and testbench
=====================================

// Module: f3_predecoder_pipe
// PURPOSE
//  Parametrised, pipelined successor of the F3 predecoder in the IFU F3 stage.
//  Per fetch slot: brType/isCall/isRet for RVI and (optionally) RVC, masked by a slot-valid vector.
//  Also reports the first-CFI index. Results are buffered in a DEPTH-entry output queue with
//  valid/ready handshakes on both sides and a flush input.
// PARAMETERS
//  FETCH_WIDTH  16  instruction slots per fetch packet (>=1)
//  DEPTH        2   output queue entries (>=1)
//  RVC_EN       1   1: decode 16-bit compressed CFIs; 0: slots with instr[1:0]!=2'b11 decode as notCFI
//  IDX_W        $clog2(FETCH_WIDTH) (min 1) width of first-CFI index
// PORTS
//  clock             in   1                clock
//  reset             in   1                synchronous active-high reset
//  io_flush          in   1                drop all queued and incoming results this cycle
//  io_in_valid       in   1                packet offered
//  io_in_ready       out  1                queue not full
//  io_in_instr       in   32*FETCH_WIDTH   slot i = bits [32i+31:32i]
//  io_in_mask        in   FETCH_WIDTH      slot-valid; masked slots decode as notCFI
//  io_out_valid      out  1                queue head valid
//  io_out_ready      in   1                consumer accepts head
//  io_out_brType     out  2*FETCH_WIDTH    per slot: 0 notCFI, 1 branch, 2 jal, 3 jalr
//  io_out_isCall     out  FETCH_WIDTH      per slot
//  io_out_isRet      out  FETCH_WIDTH      per slot
//  io_out_hasCfi     out  1                any slot brType!=0
//  io_out_firstCfi   out  IDX_W            lowest slot with brType!=0; 0 if none
// BEHAVIOUR
//  Decode (combinational on input; link = x1 or x5):
//   RVI (instr[1:0]=11): opcode 1100011 -> branch; 1101111 -> jal; 1100111 -> jalr.
//    isCall = (jal|jalr) & rd in link. isRet = jalr & rs1 in link & rd not in link.
//   RVC (RVC_EN=1): op01 f3=101 c.j -> jal; op01 f3=110/111 c.beqz/c.bnez -> branch;
//    op10 f3=100 rs2=0 rs1!=0: bit12=0 c.jr -> jalr, isRet if rs1 in link;
//    bit12=1 c.jalr -> jalr, isCall=1. All other encodings -> notCFI, isCall=isRet=0.
//   Slots are decoded independently; no half-instruction stitching across slot boundaries.
//  Queue:
//   - enq = in_valid & in_ready & !flush.
//   - deq = out_valid & out_ready.
//   - in_ready = (count != DEPTH); it does not depend on out_ready (no bypass when full).
//   - Latency is 1 cycle: a packet accepted in cycle N is at the head in N+1 at the earliest.
//   - FIFO order; outputs present the head entry and are stable while out_valid & !out_ready.
//   - Simultaneous enq and deq: count unchanged; read and write pointers both advance, modulo DEPTH.
//   - out_valid = (count != 0).
//  Flush:
//   - count <= 0 and both pointers <= 0 on the next edge; the same-cycle input is discarded.
//   - A deq in the flush cycle is still a legal handshake for the current head.
//  Reset: count=0, pointers=0, so out_valid=0 and in_ready=1. Data outputs are don't-care while out_valid=0.
//   Mid-operation reset behaves as flush.
//  Width rule: count is $clog2(DEPTH+1) bits and must never exceed DEPTH. The bench asserts
//   this, and asserts no enq while !in_ready.
// TESTING
//  1. Slot0=0x000000EF (jal ra), mask=1, rest 0 -> next cycle out_valid=1, brType[0]=2,
//     isCall[0]=1, hasCfi=1, firstCfi=0.
//  2. Slot3=0x00008067 (ret), slot5=0x00000063 (beq), mask all 1 -> brType[3]=3, isRet[3]=1,
//     brType[5]=1, firstCfi=3.
//  3. RVC_EN=1: slot1=0x00008082 (c.jr ra) -> brType 3, isRet 1; slot2=0x0000A001 (c.j) -> brType 2.
//     RVC_EN=0 gives brType 0 for both.
//  4. Same packet with mask bit3=0 -> slot3 brType 0, isRet 0, firstCfi=5.
//  5. out_ready=0 with DEPTH=2: two packets accepted, then in_ready=0 while in_valid is held.
//     Release out_ready -> FIFO order, and in_ready returns the cycle after the first deq.
//     Also drive simultaneous enq/deq at count=1 for 10 cycles -> count stays 1.
//  6. Queue full, assert io_flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     and the flushed input never appears. Repeat with reset instead of flush -> same result.

Source files
------------

// File: rtl/f3_predecoder_pipe_if.sv
// Fetch-packet predecode bus: packet in (valid/ready) and per-slot CFI results out (valid/ready).
interface f3_predecoder_pipe_if #(
  parameter int FETCH_WIDTH = 16,
  parameter int IDX_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [32*FETCH_WIDTH-1:0] in_instr;
  logic [FETCH_WIDTH-1:0]   in_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*FETCH_WIDTH-1:0] out_br_type;
  logic [FETCH_WIDTH-1:0]   out_is_call;
  logic [FETCH_WIDTH-1:0]   out_is_ret;
  logic                     out_has_cfi;
  logic [IDX_W-1:0]         out_first_cfi;

  modport master (
    output flush, in_valid, in_instr, in_mask, out_ready,
    input  in_ready, out_valid, out_br_type, out_is_call, out_is_ret,
           out_has_cfi, out_first_cfi
  );

  modport slave (
    input  flush, in_valid, in_instr, in_mask, out_ready,
    output in_ready, out_valid, out_br_type, out_is_call, out_is_ret,
           out_has_cfi, out_first_cfi
  );
endinterface

// File: rtl/f3_predecoder_pipe.sv
// Pipelined F3 predecoder: per-slot RVI/RVC CFI decode feeding a DEPTH-entry result queue.
module f3_predecoder_pipe #(
  parameter int FETCH_WIDTH = 16,
  parameter int DEPTH       = 2,
  parameter int RVC_EN      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  f3_predecoder_pipe_if.slave  io
);
  localparam int IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_BRANCH = 2'd1,
    BR_JAL    = 2'd2,
    BR_JALR   = 2'd3
  } br_t;

  typedef struct packed {
    br_t  br;
    logic call;
    logic ret;
  } slot_t;

  typedef struct packed {
    logic [2*FETCH_WIDTH-1:0] br_type;
    logic [FETCH_WIDTH-1:0]   is_call;
    logic [FETCH_WIDTH-1:0]   is_ret;
    logic                     has_cfi;
    logic [IDX_W-1:0]         first_cfi;
  } result_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic slot_t decode_slot(input logic [31:0] ins);
    slot_t      s;
    logic       rd_link;
    logic       rs1_link;
    logic [2:0] f3;
    s        = '0;
    rd_link  = is_link(ins[11:7]);
    rs1_link = is_link(ins[19:15]);
    f3       = ins[15:13];
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'b1100011: s.br = BR_BRANCH;
        7'b1101111: begin
          s.br   = BR_JAL;
          s.call = rd_link;
        end
        7'b1100111: begin
          s.br   = BR_JALR;
          s.call = rd_link;
          s.ret  = rs1_link && !rd_link;
        end
        default: ;
      endcase
    end else if (RVC_EN != 0) begin
      // For c.jr/c.jalr the source register sits in the rd field (ins[11:7])
      if (ins[1:0] == 2'b01) begin
        if (f3 == 3'b101)
          s.br = BR_JAL;
        else if (f3 == 3'b110 || f3 == 3'b111)
          s.br = BR_BRANCH;
      end else if (ins[1:0] == 2'b10 && f3 == 3'b100 &&
                   ins[6:2] == 5'd0 && ins[11:7] != 5'd0) begin
        s.br = BR_JALR;
        if (ins[12])
          s.call = 1'b1;
        else
          s.ret = rd_link;
      end
    end
    return s;
  endfunction

  result_t dec;

  always_comb begin
    slot_t s;
    dec = '0;
    s   = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      s = io.in_mask[i] ? decode_slot(io.in_instr[32*i +: 32]) : '0;
      dec.br_type[2*i +: 2] = s.br;
      dec.is_call[i]        = s.call;
      dec.is_ret[i]         = s.ret;
    end
    dec.has_cfi = |dec.br_type;
    // Scan high-to-low so the lowest CFI slot wins
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (dec.br_type[2*(FETCH_WIDTH-1-i) +: 2] != 2'd0)
        dec.first_cfi = IDX_W'(FETCH_WIDTH - 1 - i);
    end
  end

  result_t           mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              enq;
  logic              deq;

  assign io.in_ready  = (count != CNT_W'(DEPTH));
  assign io.out_valid = (count != '0);
  assign enq = io.in_valid && io.in_ready && !io.flush;
  assign deq = io.out_valid && io.out_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || io.flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq && !reset)
      mem[wr_ptr] <= dec;
  end

  assign io.out_br_type   = mem[rd_ptr].br_type;
  assign io.out_is_call   = mem[rd_ptr].is_call;
  assign io.out_is_ret    = mem[rd_ptr].is_ret;
  assign io.out_has_cfi   = mem[rd_ptr].has_cfi;
  assign io.out_first_cfi = mem[rd_ptr].first_cfi;
endmodule

// File: tb/tb_f3_predecoder_pipe.sv
// Directed bench for f3_predecoder_pipe: decode patterns, queue backpressure, flush and reset.
module tb_f3_predecoder_pipe;
  localparam int FW    = 16;
  localparam int DEPTH = 2;
  localparam int IDX_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  f3_predecoder_pipe_if #(.FETCH_WIDTH(FW)) io ();
  f3_predecoder_pipe_if #(.FETCH_WIDTH(FW)) io2 ();

  f3_predecoder_pipe #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .RVC_EN(1)) dut (
    .clock(clock), .reset(reset), .io(io));
  f3_predecoder_pipe #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .RVC_EN(0)) dut2 (
    .clock(clock), .reset(reset), .io(io2));

  assign io2.flush     = io.flush;
  assign io2.in_valid  = io.in_valid;
  assign io2.in_instr  = io.in_instr;
  assign io2.in_mask   = io.in_mask;
  assign io2.out_ready = io.out_ready;

  always @(posedge clock) begin
    if (!reset) begin
      assert (dut.count <= 2'(DEPTH)) else $error("count above DEPTH");
      assert (!(dut.enq && !io.in_ready)) else $error("enq while not ready");
    end
  end

  logic [32*FW-1:0] p1, p2, p3;

  task automatic drive(input logic v, input logic [32*FW-1:0] ins,
                       input logic [FW-1:0] m, input logic r);
    io.in_valid  = v;
    io.in_instr  = ins;
    io.in_mask   = m;
    io.out_ready = r;
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h want=0", io.out_valid); end
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h want=1", io.in_ready); end
  endtask

  task automatic test_jal_call();
    drive(1'b1, p1, 16'h0001, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL jal_valid got=%0h want=1", io.out_valid); end
    total++; if (io.out_br_type !== 32'h0000_0002) begin bad++; $display("FAIL jal_br got=%h want=00000002", io.out_br_type); end
    total++; if (io.out_is_call !== 16'h0001) begin bad++; $display("FAIL jal_call got=%h want=0001", io.out_is_call); end
    total++; if (io.out_has_cfi !== 1'b1) begin bad++; $display("FAIL jal_has got=%0h want=1", io.out_has_cfi); end
    total++; if (io.out_first_cfi !== 4'd0) begin bad++; $display("FAIL jal_first got=%0d want=0", io.out_first_cfi); end
    cyc();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL jal_drained got=%0h want=0", io.out_valid); end
  endtask

  task automatic test_ret_branch();
    drive(1'b1, p2, 16'hFFFF, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_br_type !== 32'h0000_04C0) begin bad++; $display("FAIL ret_br got=%h want=000004c0", io.out_br_type); end
    total++; if (io.out_is_ret !== 16'h0008) begin bad++; $display("FAIL ret_isret got=%h want=0008", io.out_is_ret); end
    total++; if (io.out_is_call !== 16'h0000) begin bad++; $display("FAIL ret_call got=%h want=0000", io.out_is_call); end
    total++; if (io.out_first_cfi !== 4'd3) begin bad++; $display("FAIL ret_first got=%0d want=3", io.out_first_cfi); end
    cyc();
  endtask

  task automatic test_rvc();
    drive(1'b1, p3, 16'hFFFF, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_br_type !== 32'h0000_032C) begin bad++; $display("FAIL rvc_br got=%h want=0000032c", io.out_br_type); end
    total++; if (io.out_is_ret !== 16'h0002) begin bad++; $display("FAIL rvc_ret got=%h want=0002", io.out_is_ret); end
    total++; if (io.out_is_call !== 16'h0010) begin bad++; $display("FAIL rvc_call got=%h want=0010", io.out_is_call); end
    total++; if (io.out_first_cfi !== 4'd1) begin bad++; $display("FAIL rvc_first got=%0d want=1", io.out_first_cfi); end
    total++; if (io2.out_valid !== 1'b1) begin bad++; $display("FAIL norvc_valid got=%0h want=1", io2.out_valid); end
    total++; if (io2.out_br_type !== 32'h0) begin bad++; $display("FAIL norvc_br got=%h want=00000000", io2.out_br_type); end
    total++; if (io2.out_has_cfi !== 1'b0) begin bad++; $display("FAIL norvc_has got=%0h want=0", io2.out_has_cfi); end
    total++; if ({io2.out_is_ret, io2.out_is_call} !== 32'h0) begin bad++; $display("FAIL norvc_callret got=%h want=0", {io2.out_is_ret, io2.out_is_call}); end
    cyc();
  endtask

  task automatic test_mask();
    drive(1'b1, p2, 16'hFFF7, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_br_type !== 32'h0000_0400) begin bad++; $display("FAIL mask_br got=%h want=00000400", io.out_br_type); end
    total++; if (io.out_is_ret !== 16'h0000) begin bad++; $display("FAIL mask_ret got=%h want=0000", io.out_is_ret); end
    total++; if (io.out_first_cfi !== 4'd5) begin bad++; $display("FAIL mask_first got=%0d want=5", io.out_first_cfi); end
    cyc();
  endtask

  task automatic test_backpressure();
    drive(1'b1, p1, 16'hFFFF, 1'b0);
    cyc();
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0h want=1", io.in_ready); end
    drive(1'b1, p2, 16'hFFFF, 1'b0);
    cyc();
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0h want=0", io.in_ready); end
    drive(1'b1, p3, 16'hFFFF, 1'b0);
    cyc();
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL bp_held got=%0h want=0", io.in_ready); end
    total++; if (io.out_first_cfi !== 4'd0 || io.out_br_type !== 32'h2) begin bad++; $display("FAIL bp_head_a got=%h want=00000002", io.out_br_type); end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0h want=1", io.in_ready); end
    total++; if (io.out_br_type !== 32'h0000_04C0) begin bad++; $display("FAIL bp_head_b got=%h want=000004c0", io.out_br_type); end
    cyc();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_c got=%0h want=0", io.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, p1, 16'hFFFF, 1'b0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, (k % 2 == 0) ? p2 : p1, 16'hFFFF, 1'b1);
      cyc();
      total++; if (io.out_valid !== 1'b1 || io.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_count k=%0d got=%0h%0h want=11", k, io.out_valid, io.in_ready); end
      total++; if (io.out_first_cfi !== ((k % 2 == 0) ? 4'd3 : 4'd0)) begin bad++; $display("FAIL b2b_order k=%0d got=%0d", k, io.out_first_cfi); end
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h want=0", io.out_valid); end
  endtask

  task automatic test_flush(input logic use_reset);
    drive(1'b1, p1, 16'hFFFF, 1'b0);
    cyc();
    drive(1'b1, p2, 16'hFFFF, 1'b0);
    cyc();
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL fl_full r=%0d got=%0h want=0", use_reset, io.in_ready); end
    drive(1'b1, p3, 16'hFFFF, 1'b0);
    if (use_reset) reset = 1'b1; else io.flush = 1'b1;
    cyc();
    reset = 1'b0;
    io.flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid r=%0d got=%0h want=0", use_reset, io.out_valid); end
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready r=%0d got=%0h want=1", use_reset, io.in_ready); end
    cyc();
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost r=%0d got=%0h want=0", use_reset, io.out_valid); end
    drive(1'b1, p2, 16'hFFFF, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    total++; if (io.out_first_cfi !== 4'd3 || io.out_valid !== 1'b1) begin bad++; $display("FAIL fl_after r=%0d got=%0d want=3", use_reset, io.out_first_cfi); end
    cyc();
  endtask

  initial begin
    p1 = '0; p1[31:0] = 32'h0000_00EF;
    p2 = '0; p2[32*3 +: 32] = 32'h0000_8067; p2[32*5 +: 32] = 32'h0000_0063;
    p3 = '0; p3[32*1 +: 32] = 32'h0000_8082; p3[32*2 +: 32] = 32'h0000_A001;
    p3[32*4 +: 32] = 32'h0000_9082;
    io.flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    test_reset();
    test_jal_call();
    test_ret_branch();
    test_rvc();
    test_mask();
    test_backpressure();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
